// File: rtl/cost_acc_nch_pkg.sv
// rtl/cost_acc_nch_pkg.sv - shared constants and helpers for the squared-error cost accumulator
package cost_acc_nch_pkg;

  localparam logic [31:0] ONE = 32'h0100_0000;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

  // Largest positive value of a w-bit two's complement word (w <= 64).
  function automatic logic [127:0] max_pos(input int w);
    return (128'd1 << (w - 1)) - 128'd1;
  endfunction

endpackage

// File: rtl/cost_acc_nch_sq_sat.sv
// rtl/cost_acc_nch_sq_sat.sv - saturating fixed-point squarer for one delta channel
module cost_acc_nch_sq_sat
  import cost_acc_nch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24
) (
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] sq,
  output logic             sat
);

  localparam logic [2*WIDTH-1:0] LIM = (2*WIDTH)'(max_pos(WIDTH));

  logic signed [2*WIDTH-1:0] prod;
  logic        [2*WIDTH-1:0] shifted;

  // A square is never negative, so the logical shift is exact.
  assign prod    = $signed(d) * $signed(d);
  assign shifted = prod >> FRAC;
  assign sat     = shifted > LIM;
  assign sq      = sat ? LIM[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/cost_acc_nch.sv
// rtl/cost_acc_nch.sv - batch accumulator of 0.5*sum(d_k^2) over NUM delta channels
module cost_acc_nch
  import cost_acc_nch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24,
  parameter int NUM   = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clear,
  input  logic                 i_valid,
  input  logic [NUM*WIDTH-1:0] i_d,
  input  logic [CNT_W-1:0]     i_batch,
  input  logic [4:0]           i_avg_sh,
  output logic [WIDTH-1:0]     o_cost,
  output logic                 o_valid,
  output logic                 o_sat,
  output logic [CNT_W-1:0]     o_count
);

  localparam int              SW   = WIDTH + clog2(NUM);
  localparam logic [WIDTH-1:0] MAXP = WIDTH'(max_pos(WIDTH));
  localparam logic [SW-1:0]    MAXS = SW'(max_pos(WIDTH));

  logic [NUM*WIDTH-1:0] sq_c, sq_r;
  logic [NUM-1:0]       sq_sat_c;
  logic                 v0, sat0;
  logic [SW-1:0]        sum_c, half_c;
  logic [WIDTH-1:0]     term_c, term_r;
  logic                 term_sat_c, v1, sat1;
  logic [WIDTH-1:0]     acc, acc_next, cost_c;
  logic [WIDTH:0]       add_c;
  logic                 ovf_c, sticky, close_c;
  logic [CNT_W-1:0]     count, batch_lat, eff_batch;

  for (genvar k = 0; k < NUM; k++) begin : g_sq
    cost_acc_nch_sq_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_sq_sat (
      .d   (i_d[k*WIDTH +: WIDTH]),
      .sq  (sq_c[k*WIDTH +: WIDTH]),
      .sat (sq_sat_c[k])
    );
  end

  always_comb begin
    sum_c = '0;
    for (int k = 0; k < NUM; k++) begin
      sum_c = sum_c + SW'(sq_r[k*WIDTH +: WIDTH]);
    end
    half_c     = sum_c >> 1;
    term_sat_c = half_c > MAXS;
    term_c     = term_sat_c ? MAXP : half_c[WIDTH-1:0];
  end

  // Stage 2 arithmetic; the batch size is taken live only for a batch's first sample.
  assign add_c     = {1'b0, acc} + {1'b0, term_r};
  assign ovf_c     = add_c > {1'b0, MAXP};
  assign acc_next  = ovf_c ? MAXP : add_c[WIDTH-1:0];
  assign eff_batch = (count != '0) ? batch_lat :
                     (i_batch == '0) ? CNT_W'(1) : i_batch;
  assign close_c   = v1 && ((count + 1'b1) == eff_batch);
  assign cost_c    = (32'(i_avg_sh) >= WIDTH) ? '0 : WIDTH'($signed(acc_next) >>> i_avg_sh);

  always_ff @(posedge clk) begin
    if (!rst) begin
      sq_r      <= '0;
      v0        <= 1'b0;
      sat0      <= 1'b0;
      term_r    <= '0;
      v1        <= 1'b0;
      sat1      <= 1'b0;
      acc       <= '0;
      count     <= '0;
      batch_lat <= '0;
      sticky    <= 1'b0;
      o_cost    <= '0;
      o_valid   <= 1'b0;
      o_sat     <= 1'b0;
    end else if (i_clear) begin
      v0      <= 1'b0;
      v1      <= 1'b0;
      acc     <= '0;
      count   <= '0;
      sticky  <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      v0 <= i_valid;
      if (i_valid) begin
        sq_r <= sq_c;
        sat0 <= |sq_sat_c;
      end
      v1 <= v0;
      if (v0) begin
        term_r <= term_c;
        sat1   <= sat0 | term_sat_c;
      end
      o_valid <= 1'b0;
      if (v1) begin
        if (count == '0) batch_lat <= eff_batch;
        if (close_c) begin
          o_cost  <= cost_c;
          o_sat   <= sticky | sat1 | ovf_c;
          o_valid <= 1'b1;
          acc     <= '0;
          count   <= '0;
          sticky  <= 1'b0;
        end else begin
          acc    <= acc_next;
          count  <= count + 1'b1;
          sticky <= sticky | sat1 | ovf_c;
        end
      end
    end
  end

  assign o_count = count;

endmodule
